// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundles around the round-robin arbiter: the N-master request side
// and the single shared slave port.
interface wb_mbus_if #(
    parameter int NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]    m_cyc;
    logic [NUM_MASTERS-1:0]    m_stb;
    logic [NUM_MASTERS-1:0]    m_we;
    logic [NUM_MASTERS*28-1:0] m_adr;
    logic [NUM_MASTERS*4-1:0]  m_sel;
    logic [NUM_MASTERS*32-1:0] m_dat;
    logic [NUM_MASTERS-1:0]    m_stall;
    logic [NUM_MASTERS-1:0]    m_ack;
    logic [NUM_MASTERS-1:0]    m_err;
    logic [31:0]               m_rdat;

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat,
        input  m_stall, m_ack, m_err, m_rdat
    );

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat,
        output m_stall, m_ack, m_err, m_rdat
    );
endinterface

interface wb_sbus_if;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [27:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack;
    logic        s_err;
    logic        s_stall;

    modport master (
        output s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o,
        input  s_dat_i, s_ack, s_err, s_stall
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o,
        output s_dat_i, s_ack, s_err, s_stall
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin N-to-1 Wishbone arbiter; grant held for a whole CYC, with a
// bus watchdog that turns a hung slave into an error for the owning master.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner; all masters stalled; picks next owner after lp
// BUSY    | master g owns the slave port; traffic passes through
// TO_WAIT | watchdog fired; slave cut off until master g drops CYC
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_mbus_if.slave               mbus,
    wb_sbus_if.master              sbus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout_evt
);
    localparam int GW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TCW-1:0] TC_LAST = TCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0]  LP_RST  = GW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TO_WAIT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  g_q, g_d;
    logic [GW-1:0]  lp_q, lp_d;
    logic [TCW-1:0] tc_q, tc_d;

    logic           sel_cyc, sel_stb, sel_we;
    logic [27:0]    sel_adr;
    logic [3:0]     sel_sel;
    logic [31:0]    sel_dat;
    logic           win_vld;
    logic [GW-1:0]  win_idx;
    logic           fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            lp_q    <= LP_RST;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lp_q    <= lp_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_sel = '0;
        sel_dat = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g_q == GW'(i)) begin
                sel_cyc = mbus.m_cyc[i];
                sel_stb = mbus.m_stb[i];
                sel_we  = mbus.m_we[i];
                sel_adr = mbus.m_adr[i*28 +: 28];
                sel_sel = mbus.m_sel[i*4 +: 4];
                sel_dat = mbus.m_dat[i*32 +: 32];
            end
        end
    end

    // Search starts just after the last owner, so it becomes lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!win_vld && mbus.m_cyc[(int'(lp_q) + k) % NUM_MASTERS]) begin
                win_vld = 1'b1;
                win_idx = GW'((int'(lp_q) + k) % NUM_MASTERS);
            end
        end
    end

    // A slave response in the last allowed cycle beats the watchdog.
    assign fire = WD_EN && (state_q == BUSY) && (tc_q == TC_LAST)
                  && !sbus.s_ack && !sbus.s_err;

    assign mbus.m_rdat = sbus.s_dat_i;

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        lp_d         = lp_q;
        tc_d         = tc_q;
        sbus.s_cyc   = 1'b0;
        sbus.s_stb   = 1'b0;
        sbus.s_we    = 1'b0;
        sbus.s_adr   = '0;
        sbus.s_sel   = '0;
        sbus.s_dat_o = '0;
        mbus.m_stall = '1;
        mbus.m_ack   = '0;
        mbus.m_err   = '0;
        grant        = '0;
        timeout_evt  = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    g_d     = win_idx;
                    tc_d    = '0;
                end
            end
            BUSY: begin
                grant[g_q]   = 1'b1;
                sbus.s_we    = sel_we;
                sbus.s_adr   = sel_adr;
                sbus.s_sel   = sel_sel;
                sbus.s_dat_o = sel_dat;
                if (fire) begin
                    mbus.m_err[g_q] = 1'b1;
                    timeout_evt     = 1'b1;
                    state_d         = TO_WAIT;
                end else begin
                    sbus.s_cyc        = sel_cyc;
                    sbus.s_stb        = sel_stb;
                    mbus.m_stall[g_q] = sbus.s_stall;
                    mbus.m_ack[g_q]   = sbus.s_ack;
                    mbus.m_err[g_q]   = sbus.s_err;
                    if (!sel_cyc) begin
                        state_d = IDLE;
                        lp_d    = g_q;
                    end else if (WD_EN) begin
                        tc_d = (sbus.s_ack || sbus.s_err) ? '0 : tc_q + 1'b1;
                    end
                end
            end
            TO_WAIT: begin
                grant[g_q] = 1'b1;
                if (!sel_cyc) begin
                    state_d = IDLE;
                    lp_d    = g_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts silently: nothing may reach a master in the reset cycle.
        if (rst) begin
            mbus.m_ack  = '0;
            mbus.m_err  = '0;
            timeout_evt = 1'b0;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: owner/queue model checked every cycle plus
// literal expectations for the arbitration, fairness, watchdog and reset cases.
module tb_wb_rr_arbiter;
    localparam int N  = 2;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] grant;
    logic         timeout_evt;

    int n_tests = 0;
    int n_fail  = 0;

    wb_mbus_if #(.NUM_MASTERS(N)) mbus ();
    wb_sbus_if sbus ();

    wb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mbus        (mbus),
        .sbus        (sbus),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner index (-1 = nobody), last owner, silent cycles, hung flag.
    int          own  = -1;
    int          last = N - 1;
    int          sil  = 0;
    bit          hung = 1'b0;
    bit          fire;
    logic [N-1:0] e_grant, e_stall, e_ack, e_err;
    logic        e_evt, e_cyc, e_stb, e_we;
    logic [27:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;

    always @(negedge clk) begin
        e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0;
        e_evt = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_sel = '0; e_dat = '0; fire = 1'b0;
        if (own >= 0) begin
            e_grant[own] = 1'b1;
            if (!hung) begin
                fire  = (sil == TO - 1) && !sbus.s_ack && !sbus.s_err;
                e_we  = mbus.m_we[own];
                e_adr = mbus.m_adr[own*28 +: 28];
                e_sel = mbus.m_sel[own*4 +: 4];
                e_dat = mbus.m_dat[own*32 +: 32];
                if (fire) begin
                    e_err[own] = 1'b1;
                    e_evt      = 1'b1;
                end else begin
                    e_cyc        = mbus.m_cyc[own];
                    e_stb        = mbus.m_stb[own];
                    e_stall[own] = sbus.s_stall;
                    e_ack[own]   = sbus.s_ack;
                    e_err[own]   = sbus.s_err;
                end
            end
        end
        chk("mdl_ack", mbus.m_ack, rst ? '0 : e_ack);
        chk("mdl_err", mbus.m_err, rst ? '0 : e_err);
        chk("mdl_evt", timeout_evt, rst ? 1'b0 : e_evt);
        chk("mdl_rdat", mbus.m_rdat, sbus.s_dat_i);
        if (!rst) begin
            chk("mdl_grant", grant, e_grant);
            chk("mdl_stall", mbus.m_stall, e_stall);
            chk("mdl_scyc", sbus.s_cyc, e_cyc);
            chk("mdl_sstb", sbus.s_stb, e_stb);
            chk("mdl_swe", sbus.s_we, e_we);
            chk("mdl_sadr", sbus.s_adr, e_adr);
            chk("mdl_ssel", sbus.s_sel, e_sel);
            chk("mdl_sdat", sbus.s_dat_o, e_dat);
        end

        if (rst) begin
            own = -1; last = N - 1; sil = 0; hung = 1'b0;
        end else if (own < 0) begin
            for (int k = 1; k <= N; k++)
                if (own < 0 && mbus.m_cyc[(last + k) % N]) own = (last + k) % N;
            sil = 0; hung = 1'b0;
        end else if (hung) begin
            if (!mbus.m_cyc[own]) begin last = own; own = -1; end
        end else if (fire) begin
            hung = 1'b1;
        end else if (!mbus.m_cyc[own]) begin
            last = own; own = -1;
        end else if (sbus.s_ack || sbus.s_err) begin
            sil = 0;
        end else begin
            sil++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mbus.m_cyc = '0; mbus.m_stb = '0; mbus.m_we = '0;
        mbus.m_adr = '0; mbus.m_sel = '0; mbus.m_dat = '0;
        sbus.s_dat_i = '0; sbus.s_ack = 1'b0; sbus.s_err = 1'b0; sbus.s_stall = 1'b0;
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                         input logic [27:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        mbus.m_cyc[i] = cyc;
        mbus.m_stb[i] = stb;
        mbus.m_we[i]  = we;
        mbus.m_adr[i*28 +: 28] = adr;
        mbus.m_sel[i*4 +: 4]   = sel;
        mbus.m_dat[i*32 +: 32] = dat;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_g;

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_stall", mbus.m_stall, 2'b11);
        chk("reset_scyc", sbus.s_cyc, 1'b0);
        chk("reset_ack", mbus.m_ack, 2'b00);
        chk("reset_evt", timeout_evt, 1'b0);

        // Single requester
        set_m(0, 1, 1, 0, 28'h0000010, 4'hF, 32'h0);
        #1; chk("t1_grant_lat0", grant, 2'b00);
        tick(); #1;
        chk("t1_grant", grant, 2'b01);
        chk("t1_sadr", sbus.s_adr, 28'h0000010);
        chk("t1_sstb", sbus.s_stb, 1'b1);
        chk("t1_stall", mbus.m_stall, 2'b10);
        tick(); mbus.m_stb[0] = 1'b0;
        tick(); sbus.s_ack = 1'b1; sbus.s_dat_i = 32'hDEADBEEF;
        #1;
        chk("t1_ack", mbus.m_ack, 2'b01);
        chk("t1_rdat", mbus.m_rdat, 32'hDEADBEEF);
        chk("t1_m1_stall", mbus.m_stall[1], 1'b1);
        tick(); sbus.s_ack = 1'b0; sbus.s_dat_i = '0; mbus.m_cyc[0] = 1'b0;
        tick(); #1; chk("t1_idle", grant, 2'b00);

        // Contention
        do_reset();
        set_m(0, 1, 1, 0, 28'h0000100, 4'hF, 32'h0);
        set_m(1, 1, 1, 0, 28'h0000200, 4'hF, 32'h0);
        #1;
        chk("t2_idle_grant", grant, 2'b00);
        chk("t2_idle_sstb", sbus.s_stb, 1'b0);
        tick(); #1;
        chk("t2_first", grant, 2'b01);
        chk("t2_first_adr", sbus.s_adr, 28'h0000100);
        tick(); mbus.m_stb[0] = 1'b0; sbus.s_ack = 1'b1;
        #1; chk("t2_ack0", mbus.m_ack, 2'b01);
        tick(); sbus.s_ack = 1'b0; mbus.m_cyc[0] = 1'b0;
        #1; chk("t2_hold", grant, 2'b01);
        tick(); #1; chk("t2_dead", grant, 2'b00);
        tick(); #1;
        chk("t2_second", grant, 2'b10);
        chk("t2_second_adr", sbus.s_adr, 28'h0000200);
        tick(); mbus.m_stb[1] = 1'b0; sbus.s_ack = 1'b1; sbus.s_dat_i = 32'h11111111;
        #1; chk("t2_ack1", mbus.m_ack, 2'b10);
        tick(); sbus.s_ack = 1'b0; sbus.s_dat_i = '0; mbus.m_cyc[1] = 1'b0;
        tick();
        set_m(0, 1, 1, 0, 28'h0000104, 4'h3, 32'h0);
        set_m(1, 1, 1, 0, 28'h0000204, 4'hC, 32'h0);
        tick(); #1; chk("t2_again", grant, 2'b01);
        tick(); mbus.m_stb[0] = 1'b0; sbus.s_ack = 1'b1;
        tick(); sbus.s_ack = 1'b0; mbus.m_cyc[0] = 1'b0;
        tick(); #1; chk("t2_dead2", grant, 2'b00);
        tick(); #1; chk("t2_m1_turn", grant, 2'b10);
        tick(); mbus.m_stb[1] = 1'b0; sbus.s_ack = 1'b1;
        tick(); sbus.s_ack = 1'b0; mbus.m_cyc[1] = 1'b0;
        tick();

        // Fairness: each owner re-requests right after releasing
        do_reset();
        mbus.m_cyc = 2'b11;
        tick();
        for (int r = 0; r < 4; r++) begin
            exp_g = (r % 2 == 0) ? 2'b01 : 2'b10;
            mbus.m_stb[r % 2] = 1'b1;
            #1; chk("fair_grant", grant, exp_g);
            tick(); mbus.m_stb[r % 2] = 1'b0; sbus.s_ack = 1'b1; sbus.s_dat_i = 32'h100 + r;
            #1; chk("fair_ack", mbus.m_ack, exp_g);
            tick(); sbus.s_ack = 1'b0; sbus.s_dat_i = '0; mbus.m_cyc[r % 2] = 1'b0;
            tick(); mbus.m_cyc[r % 2] = 1'b1;
            #1; chk("fair_dead", grant, 2'b00);
            tick();
        end
        mbus.m_cyc = 2'b00;
        tick(); tick();

        // Watchdog timeout on M1
        do_reset();
        set_m(1, 1, 1, 1, 28'h0003000, 4'h3, 32'hCAFEF00D);
        tick(); #1;
        chk("to_grant", grant, 2'b10);
        chk("to_swe", sbus.s_we, 1'b1);
        chk("to_sdat", sbus.s_dat_o, 32'hCAFEF00D);
        tick(); mbus.m_stb[1] = 1'b0;
        tick(); #1;
        chk("to_early_err", mbus.m_err, 2'b00);
        chk("to_early_evt", timeout_evt, 1'b0);
        tick(); #1;
        chk("to_err", mbus.m_err, 2'b10);
        chk("to_evt", timeout_evt, 1'b1);
        chk("to_scyc", sbus.s_cyc, 1'b0);
        tick(); sbus.s_ack = 1'b1;
        #1;
        chk("to_late_ack", mbus.m_ack, 2'b00);
        chk("to_wait_scyc", sbus.s_cyc, 1'b0);
        chk("to_evt_once", timeout_evt, 1'b0);
        tick(); sbus.s_ack = 1'b0; mbus.m_cyc[1] = 1'b0;
        tick(); #1; chk("to_idle", grant, 2'b00);

        // Response on the last allowed cycle beats the watchdog
        do_reset();
        set_m(0, 1, 1, 0, 28'h0000040, 4'hF, 32'h0);
        tick();
        tick(); mbus.m_stb[0] = 1'b0;
        tick();
        tick(); sbus.s_ack = 1'b1; sbus.s_dat_i = 32'h12345678;
        #1;
        chk("race_ack", mbus.m_ack, 2'b01);
        chk("race_err", mbus.m_err, 2'b00);
        chk("race_evt", timeout_evt, 1'b0);
        tick(); sbus.s_ack = 1'b0; sbus.s_dat_i = '0; mbus.m_cyc[0] = 1'b0;
        tick();

        // Reset mid-transfer (M0 was last owner, so only reset makes M0 win next)
        set_m(0, 1, 1, 0, 28'h0000080, 4'hF, 32'h0);
        sbus.s_stall = 1'b1;
        tick(); mbus.m_cyc[1] = 1'b1;
        #1;
        chk("rst_busy_grant", grant, 2'b01);
        chk("rst_busy_stall", mbus.m_stall, 2'b11);
        tick(); rst = 1'b1; sbus.s_ack = 1'b1;
        #1;
        chk("rst_no_ack", mbus.m_ack, 2'b00);
        chk("rst_no_err", mbus.m_err, 2'b00);
        tick(); rst = 1'b0; sbus.s_ack = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_stall", mbus.m_stall, 2'b11);
        chk("rst_scyc", sbus.s_cyc, 1'b0);
        chk("rst_sadr", sbus.s_adr, 28'h0);
        tick(); #1;
        chk("rst_m0_first", grant, 2'b01);
        tick(); sbus.s_stall = 1'b0; mbus.m_cyc = 2'b00;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit: got still running, want finished");
        $fatal(1, "time limit");
    end
endmodule
